// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU plus iterative multiply/divide unit.
// Ports: clk, rst, i_valid/i_op/i_a/i_b/i_rd_addr/i_stall/i_flush in; o_busy, o_valid/o_result/o_rd_addr out.
module ex_muldiv_stage #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1) + 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  logic [4:0]      r_op;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  logic            w_is_md;
  logic            w_is_div;
  logic            w_sdiv;
  logic            w_accept;
  logic            w_done;
  logic [XLEN-1:0] w_alu;
  logic [SW-1:0]   w_sh;

  assign w_is_md  = (i_op >= 5'd10) && (i_op <= 5'd17);
  assign w_is_div = (i_op >= 5'd14) && (i_op <= 5'd17);
  assign w_sdiv   = (i_op == 5'd14) || (i_op == 5'd16);
  assign w_accept = (r_state == S_IDLE) && i_valid && w_is_md
                  && !i_stall && !i_flush;
  assign w_done   = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_sh     = i_b[SW-1:0];

  // Single-cycle ALU
  always_comb begin
    w_alu = i_a + i_b;
    case (i_op)
      5'd1:    w_alu = i_a - i_b;
      5'd2:    w_alu = i_a << w_sh;
      5'd3:    w_alu = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      5'd4:    w_alu = {{(XLEN-1){1'b0}}, i_a < i_b};
      5'd5:    w_alu = i_a ^ i_b;
      5'd6:    w_alu = i_a >> w_sh;
      5'd7:    w_alu = $signed(i_a) >>> w_sh;
      5'd8:    w_alu = i_a | i_b;
      5'd9:    w_alu = i_a & i_b;
      default: w_alu = i_a + i_b;
    endcase
  end

  // Multiply from latched operands; 2*XLEN-wide extension keeps
  // the full product exact for every signedness combination.
  logic            w_sa;
  logic            w_sb;
  logic [2*XLEN-1:0] w_ma;
  logic [2*XLEN-1:0] w_mb;
  logic [2*XLEN-1:0] w_prod;

  assign w_sa   = (r_op == 5'd11) || (r_op == 5'd12);
  assign w_sb   = (r_op == 5'd11);
  assign w_ma   = {{XLEN{w_sa & r_a[XLEN-1]}}, r_a};
  assign w_mb   = {{XLEN{w_sb & r_b[XLEN-1]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // Restoring divide step on magnitudes
  logic [XLEN:0]   w_shr;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;

  assign w_shr  = {r_rem, r_quo[XLEN-1]};
  assign w_diff = w_shr - {1'b0, r_dvs};
  assign w_q    = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r    = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  logic [XLEN-1:0] w_md;
  always_comb begin
    w_md = w_prod[XLEN-1:0];
    case (r_op)
      5'd11, 5'd12, 5'd13: w_md = w_prod[2*XLEN-1:XLEN];
      5'd14, 5'd15:        w_md = w_q;
      5'd16, 5'd17:        w_md = w_r;
      default:             w_md = w_prod[XLEN-1:0];
    endcase
  end

  // FSM next state and busy
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            o_busy      = 1'b1;
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = w_is_div ? CW'(XLEN) : CW'(MUL_CYCLES - 1);
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            o_busy    = 1'b1;
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (i_stall) begin
            o_busy = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (rst) o_busy = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Operand latch and divide iterations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_op    <= i_op;
      r_rd    <= i_rd_addr;
      r_a     <= i_a;
      r_b     <= i_b;
      r_rem   <= '0;
      r_quo   <= (w_sdiv && i_a[XLEN-1]) ? (~i_a + 1'b1) : i_a;
      r_dvs   <= (w_sdiv && i_b[XLEN-1]) ? (~i_b + 1'b1) : i_b;
      // Divide by zero keeps the all-ones quotient unsigned
      r_neg_q <= w_sdiv && (i_a[XLEN-1] ^ i_b[XLEN-1]) && (i_b != '0);
      r_neg_r <= w_sdiv && i_a[XLEN-1];
    end else if ((r_state == S_BUSY) && (r_cnt != '0) && (r_op >= 5'd14)) begin
      if (!w_diff[XLEN]) begin
        r_rem <= w_diff[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shr[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  // EX/MEM output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (!i_stall) begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_done) begin
        r_valid  <= 1'b1;
        r_result <= w_md;
        r_rd_out <= r_rd;
      end else if ((r_state == S_IDLE) && i_valid && !w_is_md) begin
        r_valid  <= 1'b1;
        r_result <= w_alu;
        r_rd_out <= i_rd_addr;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_result  = r_result;
  assign o_rd_addr = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed testbench for ex_muldiv_stage (XLEN=32, MUL_CYCLES=2).
module tb_ex_muldiv_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [4:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [4:0]  i_rd_addr;
  logic        i_stall;
  logic        i_flush;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_stage #(.XLEN(32), .MUL_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_op      (i_op),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_rd_addr (i_rd_addr),
    .i_stall   (i_stall),
    .i_flush   (i_flush),
    .o_busy    (o_busy),
    .o_valid   (o_valid),
    .o_result  (o_result),
    .o_rd_addr (o_rd_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic alu(input string tag, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_rd_addr = rd;
    #1;
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    tick();
    i_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_res"}, o_result, exp);
    chk({tag, "_rd"}, {27'd0, o_rd_addr}, {27'd0, rd});
  endtask

  // Holds i_valid through the busy window; counts busy cycles T..T+n
  task automatic run_md(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int n,
                        input logic [31:0] exp);
    int busy_cnt;
    int vld_cnt;
    busy_cnt = 0;
    vld_cnt  = 0;
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_rd_addr = rd;
    for (int k = 0; k <= n; k++) begin
      #1;
      if (o_busy) busy_cnt++;
      if (k > 0 && o_valid) vld_cnt++;
      tick();
    end
    i_valid = 1'b0;
    chk({tag, "_busycyc"}, busy_cnt, n);
    chk({tag, "_novalid"}, vld_cnt, 0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_res"}, o_result, exp);
    chk({tag, "_rd"}, {27'd0, o_rd_addr}, {27'd0, rd});
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    i_rd_addr = '0; i_stall = 1'b0; i_flush = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_res", o_result, 32'd0);
    chk("rst_rd", {27'd0, o_rd_addr}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    tick();

    alu("sub", 5'd1, 32'd5, 32'd7, 5'd3, 32'hFFFF_FFFE);
    alu("slt", 5'd3, 32'hFFFF_FFFF, 32'd1, 5'd4, 32'd1);
    alu("sltu", 5'd4, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0);
    alu("sra", 5'd7, 32'h8000_0000, 32'h24, 5'd6, 32'hF800_0000);
    alu("srl", 5'd6, 32'h8000_0000, 32'h24, 5'd7, 32'h0800_0000);
    alu("sll", 5'd2, 32'h0000_0003, 32'h21, 5'd8, 32'h0000_0006);
    alu("op20", 5'd20, 32'd3, 32'd4, 5'd9, 32'd7);

    // Stall holds the output register
    i_stall = 1'b1; i_valid = 1'b1; i_op = 5'd0;
    i_a = 32'd10; i_b = 32'd20; i_rd_addr = 5'd11;
    tick();
    chk("stall_valid", {31'd0, o_valid}, 32'd1);
    chk("stall_res", o_result, 32'd7);
    chk("stall_rd", {27'd0, o_rd_addr}, 32'd9);
    i_stall = 1'b0;
    tick();
    chk("unstall_res", o_result, 32'd30);
    i_valid = 1'b0;
    tick();
    chk("idle_valid", {31'd0, o_valid}, 32'd0);

    run_md("mulh", 5'd11, 32'h8000_0000, 32'h8000_0000, 5'd1, 2,
           32'h4000_0000);
    run_md("mul", 5'd10, 32'd7, 32'hFFFF_FFFD, 5'd2, 2, 32'hFFFF_FFEB);
    run_md("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'd2, 5'd3, 2, 32'hFFFF_FFFF);
    run_md("mulhu", 5'd13, 32'hFFFF_FFFF, 32'd2, 5'd4, 2, 32'd1);
    run_md("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 33,
           32'h8000_0000);
    run_md("rem_ovf", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 33, 32'd0);
    run_md("divu_z", 5'd15, 32'd7, 32'd0, 5'd7, 33, 32'hFFFF_FFFF);
    run_md("remu_z", 5'd17, 32'd7, 32'd0, 5'd8, 33, 32'd7);
    run_md("div_neg", 5'd14, 32'hFFFF_FFF9, 32'd2, 5'd9, 33, 32'hFFFF_FFFD);
    run_md("rem_neg", 5'd16, 32'hFFFF_FFF9, 32'd2, 5'd10, 33, 32'hFFFF_FFFF);
    run_md("div_z", 5'd14, 32'hFFFF_FFF9, 32'd0, 5'd11, 33, 32'hFFFF_FFFF);
    run_md("rem_z", 5'd16, 32'hFFFF_FFF9, 32'd0, 5'd12, 33, 32'hFFFF_FFF9);

    // DIVU 100/7 with a 3-cycle stall at cnt==0
    i_valid = 1'b1; i_op = 5'd15; i_a = 32'd100; i_b = 32'd7;
    i_rd_addr = 5'd13;
    for (int k = 0; k < 33; k++) tick();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("dstall_busy", {31'd0, o_busy}, 32'd1);
      chk("dstall_res", o_result, 32'hFFFF_FFF9);
      chk("dstall_valid", {31'd0, o_valid}, 32'd0);
      tick();
    end
    i_stall = 1'b0;
    #1;
    chk("drel_busy", {31'd0, o_busy}, 32'd0);
    tick();
    i_valid = 1'b0;
    chk("drel_valid", {31'd0, o_valid}, 32'd1);
    chk("drel_res", o_result, 32'd14);
    chk("drel_rd", {27'd0, o_rd_addr}, 32'd13);

    // Flush a DIV at cnt==10
    i_valid = 1'b1; i_op = 5'd14; i_a = 32'd100; i_b = 32'd3;
    i_rd_addr = 5'd14;
    for (int k = 0; k < 23; k++) tick();
    i_flush = 1'b1;
    #1;
    chk("flush_busy", {31'd0, o_busy}, 32'd0);
    tick();
    i_flush = 1'b0;
    chk("flush_novalid", {31'd0, o_valid}, 32'd0);
    alu("post_flush_add", 5'd0, 32'd1, 32'd1, 5'd15, 32'd2);
    tick();
    chk("flush_noresult", {31'd0, o_valid}, 32'd0);

    // Reset in the middle of MULHU
    i_valid = 1'b1; i_op = 5'd13; i_a = 32'hFFFF_FFFF; i_b = 32'hFFFF_FFFF;
    i_rd_addr = 5'd16;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, o_valid}, 32'd0);
    chk("mrst_res", o_result, 32'd0);
    chk("mrst_rd", {27'd0, o_rd_addr}, 32'd0);
    chk("mrst_busy", {31'd0, o_busy}, 32'd0);
    i_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_idle", {31'd0, o_valid}, 32'd0);
    run_md("mulhu2", 5'd13, 32'hFFFF_FFFF, 32'd2, 5'd17, 2, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
